control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle control unit driving the 16-bit register/ALU datapath: fetches instructions, decodes
//  them into control words (DR/SA/SB/FS/MB/MD/RW/MP) and sequences memory, branch and halt.
//  It consumes the datapath's Z flag and BusA (jump target) and owns the PC and the instruction register (IR).
//  It sits between instruction memory, data memory and the datapath.
// PARAMETERS
//  PC_W      6       PC / address width; must match datapath AddrOut
//  IW        16      instruction width
//  RESET_PC  6'h00   PC value loaded on reset
// PORTS
//  clk_main    in   1     single system clock, rising edge
//  reset       in   1     asynchronous, active-low reset
//  imem_req    out  1     instruction fetch request
//  imem_addr   out  PC_W  fetch address (= PC)
//  imem_rdata  in   IW    instruction word, valid when imem_valid=1
//  imem_valid  in   1     fetch complete
//  dmem_req    out  1     data access request (address comes from datapath AddrOut)
//  MW          out  1     data write enable (qualifies dmem_req)
//  dmem_ready  in   1     data access complete; load data is valid on datapath DataIn in the same cycle
//  DR,SA,SB    out  4     register addresses = IR[11:8], IR[7:4], IR[3:0]
//  FS          out  4     ALU function select
//  MB,MD,RW,MP out  1     datapath mux selects and register write enable
//  PC          out  PC_W  link value = PC+1, used by JAL through the datapath's MP mux
//  BusA        in   16    datapath A bus (JMP/JAL target = BusA[PC_W-1:0])
//  Z           in   1     ALU zero flag
//  halted      out  1     1 while in HALT
//  illegal     out  1     sticky illegal-opcode flag
// BEHAVIOUR
//  Instruction format: op=IR[15:12], DR=IR[11:8], SA=IR[7:4], SB=IR[3:0].
//  Opcodes:
//   0x0      NOP
//   0x1-0x7  ALU: FS={0,op[2:0]}, MB=0, RW=1
//   0x8      LDI: MB=1, FS=FS_PASSB, RW=1
//   0x9      LD:  MD=1; RW=1 in the dmem_ready cycle
//   0xA      ST:  MW=1
//   0xB      BRZ: FS=FS_PASSA; if Z, PC <= PC+1+sext(IR[11:8]), else PC <= PC+1
//   0xC      JMP: PC <= BusA[5:0]
//   0xD      JAL: MP=1, RW=1, PC <= BusA[5:0]
//   0xE      reserved
//   0xF      HALT
//  States:
//   FETCH: imem_req=1 until imem_valid; then IR <= imem_rdata and go to EXEC.
//   EXEC: one cycle for ALU/LDI/BRZ/JMP/JAL/NOP, then PC updated and back to FETCH.
//         LD/ST go to MEM; HALT goes to HALT.
//   MEM:  dmem_req=1 (and MW=1 for ST) held stable until dmem_ready; in that cycle RW=1 for LD and PC <= PC+1,
//         then FETCH.
//   HALT: terminal; halted=1. Left only by reset.
//  Control outputs are combinational from state and IR. RW, MW, dmem_req and imem_req are 0 in every
//   state other than the one that uses them. FS, MB, MD and MP are 0 when unused.
//  PC arithmetic is modulo 2^PC_W; both branch offset and +1 wrap (e.g. 63+1=0).
//  JAL with DR==SA: the target is the old R[SA], because the register file writes at the clock edge.
//  imem_valid outside FETCH and dmem_ready outside MEM are ignored.
//  Reset (async, any state): state=FETCH, PC=RESET_PC, IR=0, halted=0, illegal=0. All requests drop
//   immediately and any in-flight memory access is abandoned. First imem_req occurs in the first cycle
//   after reset release.
// CONFIGURATION
//  TRAP_ILLEGAL_EN defined: opcode 0xE sets illegal=1 (sticky) and goes to HALT.
//  TRAP_ILLEGAL_EN undefined: 0xE executes as NOP; illegal is tied to 0.
// STRUCTURE
//  Shared package: opcode localparams (OP_NOP..OP_HALT), FS constants (FS_PASSA, FS_PASSB, FS_ADD),
//   state encoding, and the control-word field positions.
//  One sub-module: cs_decoder (combinational op+state -> control word). The FSM, PC and IR stay in the top.
// TESTING
//  1. Reset with RESET_PC=0, release; imem_valid with 0x1123 -> EXEC: RW=1, FS=1, DR=1, SA=2, SB=3; next FETCH
//     with imem_addr=1.
//  2. LD 0x9540, dmem_ready held low 3 cycles -> dmem_req=1 and MD=1 for 4 cycles, RW=1 only in the ready cycle,
//     PC+1.
//  3. BRZ 0xBE00 at PC=5 with Z=1 -> PC=4 (5+1-2). Same with Z=0 -> PC=6. At PC=63 with Z=0 -> PC=0.
//  4. JAL 0xD770 at PC=10, BusA=0x0021 -> MP=1, RW=1, PC output=11, next imem_addr=0x21.
//  5. Reset asserted mid-MEM (ST, dmem_ready=0) -> dmem_req and MW drop asynchronously, PC=RESET_PC, FETCH after
//     release.
//  6. 0xE000 with TRAP_ILLEGAL_EN -> illegal=1, halted=1, no further imem_req. Without the macro -> NOP, PC+1.
//     0xF000 -> halted=1 permanently.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// control_sequencer_pkg
// Shared definitions for the multi-cycle control sequencer:
//   - opcode values (OP_NOP .. OP_HALT)
//   - ALU function-select constants used by the sequencer (FS_PASSA, FS_PASSB, FS_ADD)
//   - sequencer state encoding
//   - control word layout (the packed struct fixes the field positions)
// -----------------------------------------------------------------------------
package control_sequencer_pkg;

    // Opcodes, IR[15:12]; 0x1-0x7 are the register-register ALU group
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BRZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_RSVD = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU function selects the sequencer drives on its own
    localparam logic [3:0] FS_PASSA = 4'h0;
    localparam logic [3:0] FS_ADD   = 4'h2;
    localparam logic [3:0] FS_PASSB = 4'h8;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Control word, MSB first: request/enable bits, mux selects, FS, then register addresses
    typedef struct packed {
        logic       imemReq;
        logic       dmemReq;
        logic       mw;
        logic       rw;
        logic       mb;
        logic       md;
        logic       mp;
        logic [3:0] fs;
        logic [3:0] dr;
        logic [3:0] sa;
        logic [3:0] sb;
    } ctrl_word_t;

    localparam int CW_W = $bits(ctrl_word_t);

endpackage

// File: rtl/control_sequencer_decoder.sv
// -----------------------------------------------------------------------------
// cs_decoder
// Purely combinational: sequencer state + instruction register -> control word.
// Every enable/request is low outside the state that uses it; FS/MB/MD/MP are
// low whenever the current instruction/state does not need them.
// Ports:
//   state      in   state_t      current sequencer state
//   ir         in   [15:0]       instruction register
//   dmemReady  in   1            data access complete (qualifies RW for LD)
//   cw         out  ctrl_word_t  decoded control word
// -----------------------------------------------------------------------------
module cs_decoder
    import control_sequencer_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic        dmemReady,
    output ctrl_word_t  cw
);

    logic [3:0] op_s;
    assign op_s = ir[15:12];

    // Control word decode from state and opcode
    always_comb begin
        cw    = '0;
        cw.dr = ir[11:8];
        cw.sa = ir[7:4];
        cw.sb = ir[3:0];
        case (state)
            ST_FETCH: begin
                cw.imemReq = 1'b1;
            end
            ST_EXEC: begin
                case (op_s)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        cw.fs = {1'b0, op_s[2:0]};
                        cw.rw = 1'b1;
                    end
                    OP_LDI: begin
                        cw.mb = 1'b1;
                        cw.fs = FS_PASSB;
                        cw.rw = 1'b1;
                    end
                    OP_BRZ: begin
                        cw.fs = FS_PASSA;
                    end
                    OP_JAL: begin
                        // Link value PC+1 goes through the MP mux into R[DR]
                        cw.mp = 1'b1;
                        cw.rw = 1'b1;
                    end
                    default: begin
                        cw.fs = 4'h0;
                    end
                endcase
            end
            ST_MEM: begin
                // MEM is only entered by LD or ST
                cw.dmemReq = 1'b1;
                if (op_s == OP_ST) begin
                    cw.mw = 1'b1;
                end else begin
                    cw.md = 1'b1;
                    cw.rw = dmemReady;
                end
            end
            default: begin
                cw.imemReq = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Multi-cycle control unit for the 16-bit register/ALU datapath. Fetches an
// instruction, decodes it into DR/SA/SB/FS/MB/MD/RW/MP, and sequences data
// memory, branches, jumps and halt. Owns PC and IR.
// Build option: define TRAP_ILLEGAL_EN to make opcode 0xE set the sticky
// illegal flag and halt; otherwise 0xE is a NOP and illegal is tied low.
// Ports:
//   clk_main, reset(async, active-low)
//   imem_req/imem_addr/imem_rdata/imem_valid   instruction fetch handshake
//   dmem_req/MW/dmem_ready                     data access handshake
//   DR,SA,SB,FS,MB,MD,RW,MP                    datapath control word
//   PC (link = PC+1), BusA (jump target), Z    datapath interface
//   halted, illegal                            status
// -----------------------------------------------------------------------------
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int              PC_W     = 6,
    parameter int              IW       = 16,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk_main,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    input  logic            imem_valid,
    output logic            dmem_req,
    output logic            MW,
    input  logic            dmem_ready,
    output logic [3:0]      DR,
    output logic [3:0]      SA,
    output logic [3:0]      SB,
    output logic [3:0]      FS,
    output logic            MB,
    output logic            MD,
    output logic            RW,
    output logic            MP,
    output logic [PC_W-1:0] PC,
    input  logic [15:0]     BusA,
    input  logic            Z,
    output logic            halted,
    output logic            illegal
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_r, stateNext_s;
    logic [PC_W-1:0] pc_r, pcNext_s, pcInc_s, brOff_s;
    logic [IW-1:0]   ir_r, irNext_s;
    logic            started_r;
    logic [3:0]      op_s;
    ctrl_word_t      cw_s;
    logic            unusedBusA_s;
`ifdef TRAP_ILLEGAL_EN
    logic            illegal_r, illegalNext_s;
`endif

    assign op_s    = ir_r[15:12];
    assign pcInc_s = pc_r + PC_ONE;
    // 4-bit signed branch offset from the DR field
    assign brOff_s = {{(PC_W-4){ir_r[11]}}, ir_r[11:8]};
    // Only the low PC_W bits of BusA form a target
    assign unusedBusA_s = ^BusA[15:PC_W];

    cs_decoder u_decoder (
        .state     (state_r),
        .ir        (ir_r[15:0]),
        .dmemReady (dmem_ready),
        .cw        (cw_s)
    );

    // Sequencer state, PC, IR; started_r keeps fetch requests off until after reset release
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_PC;
            ir_r      <= {IW{1'b0}};
            started_r <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            pc_r      <= pcNext_s;
            ir_r      <= irNext_s;
            started_r <= 1'b1;
        end
    end

`ifdef TRAP_ILLEGAL_EN
    // Sticky illegal-opcode flag
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegalNext_s;
        end
    end
`endif

    // Next-state, next-PC and IR load
    always_comb begin
        stateNext_s = state_r;
        pcNext_s    = pc_r;
        irNext_s    = ir_r;
`ifdef TRAP_ILLEGAL_EN
        illegalNext_s = illegal_r;
`endif
        case (state_r)
            ST_FETCH: begin
                if (started_r && imem_valid) begin
                    irNext_s    = imem_rdata;
                    stateNext_s = ST_EXEC;
                end else begin
                    stateNext_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                stateNext_s = ST_FETCH;
                pcNext_s    = pcInc_s;
                case (op_s)
                    OP_LD, OP_ST: begin
                        stateNext_s = ST_MEM;
                        pcNext_s    = pc_r;
                    end
                    OP_BRZ: begin
                        pcNext_s = Z ? (pcInc_s + brOff_s) : pcInc_s;
                    end
                    OP_JMP, OP_JAL: begin
                        pcNext_s = BusA[PC_W-1:0];
                    end
                    OP_HALT: begin
                        stateNext_s = ST_HALT;
                        pcNext_s    = pc_r;
                    end
`ifdef TRAP_ILLEGAL_EN
                    OP_RSVD: begin
                        stateNext_s   = ST_HALT;
                        pcNext_s      = pc_r;
                        illegalNext_s = 1'b1;
                    end
`endif
                    default: begin
                        pcNext_s = pcInc_s;
                    end
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    pcNext_s    = pcInc_s;
                    stateNext_s = ST_FETCH;
                end else begin
                    stateNext_s = ST_MEM;
                end
            end
            ST_HALT: begin
                stateNext_s = ST_HALT;
            end
            default: begin
                stateNext_s = ST_FETCH;
            end
        endcase
    end

    assign imem_req  = cw_s.imemReq & started_r;
    assign imem_addr = pc_r;
    assign dmem_req  = cw_s.dmemReq;
    assign MW        = cw_s.mw;
    assign DR        = cw_s.dr;
    assign SA        = cw_s.sa;
    assign SB        = cw_s.sb;
    assign FS        = cw_s.fs;
    assign MB        = cw_s.mb;
    assign MD        = cw_s.md;
    assign RW        = cw_s.rw;
    assign MP        = cw_s.mp;
    assign PC        = pcInc_s;
    assign halted    = (state_r == ST_HALT);
`ifdef TRAP_ILLEGAL_EN
    assign illegal   = illegal_r;
`else
    assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench for control_sequencer: reset, ALU/LDI decode, LD wait states,
// BRZ taken/not-taken/wrap, JAL link and target, reset during a store,
// reserved opcode (with and without TRAP_ILLEGAL_EN) and HALT.
// Inputs are driven and outputs sampled around the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_sequencer;

    logic        clk_main;
    logic        reset;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        dmem_req;
    logic        MW;
    logic        dmem_ready;
    logic [3:0]  DR, SA, SB, FS;
    logic        MB, MD, RW, MP;
    logic [5:0]  PC;
    logic [15:0] BusA;
    logic        Z;
    logic        halted;
    logic        illegal;

    int nChecks = 0;
    int nFails  = 0;

    control_sequencer dut (
        .clk_main   (clk_main),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .dmem_req   (dmem_req),
        .MW         (MW),
        .dmem_ready (dmem_ready),
        .DR         (DR),
        .SA         (SA),
        .SB         (SB),
        .FS         (FS),
        .MB         (MB),
        .MD         (MD),
        .RW         (RW),
        .MP         (MP),
        .PC         (PC),
        .BusA       (BusA),
        .Z          (Z),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial clk_main = 1'b0;
    always #5 clk_main = ~clk_main;

    // Hold reset for two cycles, then release on a falling edge
    task automatic resetDut();
        reset      = 1'b0;
        imem_rdata = 16'h0000;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        BusA       = 16'h0000;
        Z          = 1'b0;
        @(negedge clk_main);
        @(negedge clk_main);
        reset = 1'b1;
        @(negedge clk_main);
    endtask

    // Wait (bounded) for a fetch request and answer it; returns at the EXEC falling edge
    task automatic issue(input logic [15:0] instr);
        int waitCnt = 0;
        while (imem_req !== 1'b1 && waitCnt < 20) begin
            @(negedge clk_main);
            waitCnt++;
        end
        if (imem_req !== 1'b1) begin
            nChecks++; nFails++;
            $display("FAIL issue_timeout instr=%h imem_req=%b expected 1", instr, imem_req);
        end
        imem_rdata = instr;
        imem_valid = 1'b1;
        @(negedge clk_main);
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
    endtask

    // JMP through BusA to move PC to a chosen address; returns in FETCH
    task automatic jumpTo(input logic [5:0] target);
        issue(16'hC000);
        BusA = {10'h000, target};
        @(negedge clk_main);
        BusA = 16'h0000;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        imem_rdata = 16'h0000;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        BusA       = 16'h0000;
        Z          = 1'b0;
        @(negedge clk_main);
        @(negedge clk_main);
        nChecks++;
        if (imem_req !== 1'b0 || dmem_req !== 1'b0 || MW !== 1'b0 || RW !== 1'b0) begin
            nFails++;
            $display("FAIL reset_reqs imem_req=%b dmem_req=%b MW=%b RW=%b expected all 0", imem_req, dmem_req, MW, RW);
        end
        nChecks++;
        if (imem_addr !== 6'd0 || PC !== 6'd1 || halted !== 1'b0 || illegal !== 1'b0) begin
            nFails++;
            $display("FAIL reset_state imem_addr=%0d PC=%0d halted=%b illegal=%b expected 0/1/0/0", imem_addr, PC, halted, illegal);
        end
        reset = 1'b1;
        @(negedge clk_main);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 6'd0) begin
            nFails++;
            $display("FAIL first_fetch imem_req=%b imem_addr=%0d expected 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_alu();
        issue(16'h1123);
        nChecks++;
        if (RW !== 1'b1 || FS !== 4'h1 || DR !== 4'h1 || SA !== 4'h2 || SB !== 4'h3 || MB !== 1'b0 || imem_req !== 1'b0) begin
            nFails++;
            $display("FAIL alu_decode RW=%b FS=%h DR=%h SA=%h SB=%h MB=%b imem_req=%b expected 1/1/1/2/3/0/0", RW, FS, DR, SA, SB, MB, imem_req);
        end
        @(negedge clk_main);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 6'd1 || RW !== 1'b0) begin
            nFails++;
            $display("FAIL alu_next imem_req=%b imem_addr=%0d RW=%b expected 1/1/0", imem_req, imem_addr, RW);
        end
        issue(16'h8300);
        nChecks++;
        if (MB !== 1'b1 || RW !== 1'b1 || FS !== 4'h8 || DR !== 4'h3) begin
            nFails++;
            $display("FAIL ldi_decode MB=%b RW=%b FS=%h DR=%h expected 1/1/8/3", MB, RW, FS, DR);
        end
        @(negedge clk_main);
        nChecks++;
        if (imem_addr !== 6'd2) begin
            nFails++;
            $display("FAIL ldi_next imem_addr=%0d expected 2", imem_addr);
        end
    endtask

    task automatic test_load_wait();
        issue(16'h9540);
        nChecks++;
        if (dmem_req !== 1'b0 || MD !== 1'b0 || RW !== 1'b0 || DR !== 4'h5) begin
            nFails++;
            $display("FAIL ld_exec dmem_req=%b MD=%b RW=%b DR=%h expected 0/0/0/5", dmem_req, MD, RW, DR);
        end
        @(negedge clk_main);
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            #1;
            nChecks++;
            if (dmem_req !== 1'b1 || MD !== 1'b1 || MW !== 1'b0 || RW !== (i == 3) || imem_req !== 1'b0) begin
                nFails++;
                $display("FAIL ld_mem cycle=%0d dmem_req=%b MD=%b MW=%b RW=%b imem_req=%b expected 1/1/0/%b/0", i, dmem_req, MD, MW, RW, imem_req, (i == 3));
            end
            @(negedge clk_main);
        end
        dmem_ready = 1'b0;
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 6'd3 || dmem_req !== 1'b0 || MD !== 1'b0) begin
            nFails++;
            $display("FAIL ld_done imem_req=%b imem_addr=%0d dmem_req=%b MD=%b expected 1/3/0/0", imem_req, imem_addr, dmem_req, MD);
        end
    endtask

    task automatic test_branch();
        logic [5:0] startPc [4]  = '{6'd5, 6'd5, 6'd63, 6'd0};
        logic       zIn     [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [5:0] expPc   [4]  = '{6'd4, 6'd6, 6'd0, 6'd63};
        for (int k = 0; k < 4; k++) begin
            jumpTo(startPc[k]);
            nChecks++;
            if (imem_addr !== startPc[k]) begin
                nFails++;
                $display("FAIL jmp_target case=%0d imem_addr=%0d expected %0d", k, imem_addr, startPc[k]);
            end
            issue(16'hBE00);
            Z = zIn[k];
            #1;
            nChecks++;
            if (RW !== 1'b0 || FS !== 4'h0 || dmem_req !== 1'b0) begin
                nFails++;
                $display("FAIL brz_decode case=%0d RW=%b FS=%h dmem_req=%b expected 0/0/0", k, RW, FS, dmem_req);
            end
            @(negedge clk_main);
            Z = 1'b0;
            nChecks++;
            if (imem_addr !== expPc[k]) begin
                nFails++;
                $display("FAIL brz_target case=%0d imem_addr=%0d expected %0d", k, imem_addr, expPc[k]);
            end
        end
    endtask

    task automatic test_jal();
        jumpTo(6'd10);
        issue(16'hD770);
        BusA = 16'h0021;
        #1;
        nChecks++;
        if (MP !== 1'b1 || RW !== 1'b1 || PC !== 6'd11 || DR !== 4'h7 || SA !== 4'h7) begin
            nFails++;
            $display("FAIL jal_decode MP=%b RW=%b PC=%0d DR=%h SA=%h expected 1/1/11/7/7", MP, RW, PC, DR, SA);
        end
        @(negedge clk_main);
        BusA = 16'h0000;
        nChecks++;
        if (imem_addr !== 6'h21 || MP !== 1'b0 || RW !== 1'b0) begin
            nFails++;
            $display("FAIL jal_target imem_addr=%h MP=%b RW=%b expected 21/0/0", imem_addr, MP, RW);
        end
    endtask

    task automatic test_reset_mid_store();
        issue(16'hA123);
        @(negedge clk_main);
        nChecks++;
        if (dmem_req !== 1'b1 || MW !== 1'b1 || RW !== 1'b0) begin
            nFails++;
            $display("FAIL st_mem dmem_req=%b MW=%b RW=%b expected 1/1/0", dmem_req, MW, RW);
        end
        #2;
        reset = 1'b0;
        #1;
        nChecks++;
        if (dmem_req !== 1'b0 || MW !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 6'd0) begin
            nFails++;
            $display("FAIL st_async_reset dmem_req=%b MW=%b imem_req=%b imem_addr=%0d expected 0/0/0/0", dmem_req, MW, imem_req, imem_addr);
        end
        @(negedge clk_main);
        reset = 1'b1;
        @(negedge clk_main);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 6'd0 || dmem_req !== 1'b0) begin
            nFails++;
            $display("FAIL st_refetch imem_req=%b imem_addr=%0d dmem_req=%b expected 1/0/0", imem_req, imem_addr, dmem_req);
        end
    endtask

    task automatic test_illegal();
        issue(16'hE000);
        @(negedge clk_main);
`ifdef TRAP_ILLEGAL_EN
        nChecks++;
        if (illegal !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
            nFails++;
            $display("FAIL trap_enter illegal=%b halted=%b imem_req=%b expected 1/1/0", illegal, halted, imem_req);
        end
        imem_valid = 1'b1;
        imem_rdata = 16'h1123;
        repeat (3) @(negedge clk_main);
        imem_valid = 1'b0;
        nChecks++;
        if (illegal !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || RW !== 1'b0) begin
            nFails++;
            $display("FAIL trap_sticky illegal=%b halted=%b imem_req=%b RW=%b expected 1/1/0/0", illegal, halted, imem_req, RW);
        end
`else
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 6'd1 || illegal !== 1'b0 || halted !== 1'b0) begin
            nFails++;
            $display("FAIL rsvd_nop imem_req=%b imem_addr=%0d illegal=%b halted=%b expected 1/1/0/0", imem_req, imem_addr, illegal, halted);
        end
`endif
    endtask

    task automatic test_halt();
        resetDut();
        issue(16'hF000);
        nChecks++;
        if (halted !== 1'b0 || RW !== 1'b0) begin
            nFails++;
            $display("FAIL halt_exec halted=%b RW=%b expected 0/0", halted, RW);
        end
        @(negedge clk_main);
        imem_valid = 1'b1;
        imem_rdata = 16'h1123;
        dmem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0 || RW !== 1'b0) begin
                nFails++;
                $display("FAIL halt_hold cycle=%0d halted=%b imem_req=%b dmem_req=%b RW=%b expected 1/0/0/0", i, halted, imem_req, dmem_req, RW);
            end
            @(negedge clk_main);
        end
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_jal();
        test_reset_mid_store();
        test_illegal();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
